button_debouncer: RTL and testbench

Conditions one raw front-panel push-button input before it reaches the single-pulse generator and the oscilloscope control logic. The block synchronizes the asynchronous pin to `clock` and rejects contact bounce. A level change is accepted only after the synchronized input has held the new level for a programmable number of consecutive cycles. Outputs are a clean level, which is what drives the single-pulse stage, plus one-cycle rise and fall strobes.

---
 rtl/button_debouncer.sv | 99 +++++++++
 tb/tb_button_debouncer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the raw pin to clock and accepts a new
// level only after it has been held for DEBOUNCE_CYCLES consecutive samples.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_rise,
  output logic btn_fall
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    ARM_HIGH,
    STABLE_HIGH,
    ARM_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;

  // Only sync_q[0] ever looks at the asynchronous pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The commit fires on the sample that would make cnt reach DEBOUNCE_CYCLES,
  // so the counter tops out at DEBOUNCE_CYCLES-1 and never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= STABLE_LOW;
      cnt       <= '0;
      btn_clean <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            state <= ARM_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        ARM_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_HIGH;
            btn_clean <= 1'b1;
            btn_rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= ARM_LOW;
            cnt   <= CNT_ONE;
          end
        end
        ARM_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_LOW;
            btn_clean <= 1'b0;
            btn_fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
// so an accepted level change lands 6 edges after the first capture edge.
module tb_button_debouncer;

  logic clock;
  logic reset;
  logic btn_raw;
  logic btn_clean;
  logic btn_rise;
  logic btn_fall;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3),
    .SYNC_STAGES    (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each posedge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
  endtask

  task automatic checkOutput(input string tag, input logic exp_clean,
                             input logic exp_rise, input logic exp_fall);
    checks++;
    assert (btn_clean === exp_clean) else begin
      errors++;
      $error("[TB] FAIL %s btn_clean: observed %b expected %b", tag, btn_clean, exp_clean);
    end
    checks++;
    assert (btn_rise === exp_rise) else begin
      errors++;
      $error("[TB] FAIL %s btn_rise: observed %b expected %b", tag, btn_rise, exp_rise);
    end
    checks++;
    assert (btn_fall === exp_fall) else begin
      errors++;
      $error("[TB] FAIL %s btn_fall: observed %b expected %b", tag, btn_fall, exp_fall);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      checkOutput("idle_low", 1'b0, 1'b0, 1'b0);
    end

    // Clean press: edge e is the e-th edge with btn_raw=1 at its input.
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      checkOutput($sformatf("press_e%0d", e), (e >= 6), (e == 6), 1'b0);
    end

    // Release from btn_clean=1.
    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      checkOutput($sformatf("release_e%0d", e), (e < 6), 1'b0, (e == 6));
    end

    // Bounce 1,0,1,1,0 then hold low: never reaches the 4th stable sample.
    begin
      logic [4:0] pattern;
      pattern = 5'b10110;
      for (int e = 0; e < 5; e++) begin
        applyStimulus(pattern[4-e], 1'b0);
        tick();
        checkOutput($sformatf("bounce_e%0d", e), 1'b0, 1'b0, 1'b0);
      end
    end
    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      checkOutput($sformatf("bounce_hold_e%0d", e), 1'b0, 1'b0, 1'b0);
    end

    // Bouncy press: high 3, low 1, then high; the low s-sample arrives when
    // cnt=3, so it must reject rather than commit. Final rise captured at e=5.
    for (int e = 1; e <= 20; e++) begin
      applyStimulus((e == 4) ? 1'b0 : 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("bouncy_e%0d", e), (e >= 10), (e == 10), 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      checkOutput($sformatf("bouncy_rel_e%0d", e), (e < 6), 1'b0, (e == 6));
    end

    // Reset mid-arm: edges 3,4 put the FSM in ARM_HIGH with cnt=2.
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      checkOutput($sformatf("arm_e%0d", e), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("reset_mid_arm", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      checkOutput($sformatf("post_reset_e%0d", e), (e >= 6), (e == 6), 1'b0);
    end

    // Reset while btn_clean=1: drops with no fall strobe; raw still high
    // after release counts as a fresh press.
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("reset_while_high", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      checkOutput($sformatf("repress_e%0d", e), (e >= 6), (e == 6), 1'b0);
    end

    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      checkOutput($sformatf("final_rel_e%0d", e), (e < 6), 1'b0, (e == 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
